// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants, fetch FSM state and
// instruction width. Imported by the fetch stage and its helpers.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetchState_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates for the held instruction.
// Ports:
//   ifPc         - address of the held instruction
//   instrLow     - instruction bits [25:0] (jump index / branch offset)
//   pc4          - ifPc + 4
//   branchTarget - pc4 + (sign-extended offset << 2)
//   jumpTarget   - {pc4[PC_W-1:28], index, 2'b00}
// All arithmetic wraps modulo 2^PC_W.
module pc_target_calc #(
  parameter int unsigned PC_W = 32
) (
  input  logic [PC_W-1:0] ifPc,
  input  logic [25:0]     instrLow,
  output logic [PC_W-1:0] pc4,
  output logic [PC_W-1:0] branchTarget,
  output logic [PC_W-1:0] jumpTarget
);

  logic [PC_W-1:0] branchOffset;

  // Word offset sign-extended to PC width and scaled to bytes.
  assign branchOffset = {{(PC_W-18){instrLow[15]}}, instrLow[15:0], 2'b00};

  assign pc4          = ifPc + PC_W'(4);
  assign branchTarget = pc4 + branchOffset;
  assign jumpTarget   = {pc4[PC_W-1:28], instrLow, 2'b00};

endmodule

// File: rtl/mips_instr_fetch.sv
// Instruction fetch/sequencing stage of the single-issue MIPS core.
// Owns the PC, fetches words over a req/ack handshake, holds each word for
// the decoder on a valid/ready handshake, and redirects on taken beq / j.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   imem_req/addr       - fetch request and word-aligned address
//   imem_ack/rdata      - fetch response strobe and instruction word
//   if_valid/ready      - decoder handshake
//   if_instr/op/pc      - held instruction, its opcode field and address
//   branch, zero, jump  - controls sampled in the consume cycle
//   redirect            - one-cycle pulse after a taken consume
// Optional (macro FETCH_PERF_EN): perf_fetched, perf_stall, perf_redirect
// saturating counters.
module mips_instr_fetch
  import mips_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [OP_W-1:0]    if_op,
  output logic [PC_W-1:0]    if_pc,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  output logic               redirect
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall,
  output logic [15:0]        perf_redirect
`endif
);

  localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_W-1:2], 2'b00};

  fetchState_t     state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] branchTarget;
  logic [PC_W-1:0] jumpTarget;
  logic [PC_W-1:0] nextPc;
  logic            consume;
  logic            taken;

  pc_target_calc #(.PC_W(PC_W)) targetCalc (
    .ifPc         (if_pc),
    .instrLow     (if_instr[25:0]),
    .pc4          (pc4),
    .branchTarget (branchTarget),
    .jumpTarget   (jumpTarget)
  );

  // Request follows the state but is gated by rst so it drops the moment reset rises.
  assign imem_req  = (state == FETCH) & ~rst;
  assign imem_addr = pc;
  assign if_op     = if_instr[31:26];

  assign consume = (state == HOLD) & if_valid & if_ready;
  assign taken   = jump | (branch & zero);

  // Jump wins over branch when both are asserted.
  always_comb begin
    nextPc = pc4;
    if (jump) begin
      nextPc = jumpTarget;
    end else if (branch & zero) begin
      nextPc = branchTarget;
    end
  end

  // Fetch sequencing FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC_ALIGNED;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      redirect <= 1'b0;
    end else begin
      redirect <= 1'b0;
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if_instr <= imem_rdata;
            if_pc    <= pc;
            if_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (consume) begin
            if_valid <= 1'b0;
            pc       <= nextPc;
            redirect <= taken;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_stall    <= '0;
      perf_redirect <= '0;
    end else begin
      if (consume && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if ((state == FETCH) && !imem_ack && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (consume && taken && (perf_redirect != '1)) begin
        perf_redirect <= perf_redirect + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_instr_fetch.sv
// Directed bench for mips_instr_fetch: a scoreboard queue holds the expected
// (instr, pc) for each acked fetch and is popped when if_valid appears.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mips_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [5:0]  if_op;
  logic [31:0] if_pc;
  logic        branch;
  logic        zero;
  logic        jump;
  logic        redirect;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [15:0] perf_redirect;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetchExp_t;

  fetchExp_t sb[$];
  int testsRun  = 0;
  int failCount = 0;
  int nConsumed = 0;
  int nRedirect = 0;
  int nStall    = 0;

  mips_instr_fetch #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_op      (if_op),
    .if_pc      (if_pc),
    .branch     (branch),
    .zero       (zero),
    .jump       (jump),
    .redirect   (redirect)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall),
    .perf_redirect (perf_redirect)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // Serve one fetch at addr after 'waits' unacked request cycles, then check the held word.
  task automatic fetchStep(input int waits, input logic [31:0] rdata, input logic [31:0] addr);
    fetchExp_t e;
    check("req_issue", {31'b0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, addr);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check("req_wait", {31'b0, imem_req}, 32'd1);
      check("addr_stable", imem_addr, addr);
      check("valid_wait", {31'b0, if_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    sb.push_back('{instr: rdata, pc: addr});
    nStall += waits;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom();
    check("req_drop", {31'b0, imem_req}, 32'd0);
    check("valid_set", {31'b0, if_valid}, 32'd1);
    check("redirect_low", {31'b0, redirect}, 32'd0);
    testsRun++;
    assert (sb.size() != 0) else begin
      failCount++;
      $error("FAIL scoreboard_empty observed=%0d expected=1", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("if_instr", if_instr, e.instr);
      check("if_pc", if_pc, e.pc);
      check("if_op", {26'b0, if_op}, {26'b0, e.instr[31:26]});
    end
  endtask

  // Consume the held word with the given controls and check the redirect/re-request.
  task automatic consume(input logic b, input logic z, input logic j,
                         input logic expRedir, input logic [31:0] nextAddr);
    if_ready = 1'b1;
    branch   = b;
    zero     = z;
    jump     = j;
    @(negedge clk);
    if_ready = 1'b0;
    branch   = 1'($urandom());
    zero     = 1'($urandom());
    jump     = 1'($urandom());
    nConsumed++;
    if (expRedir) nRedirect++;
    check("valid_clear", {31'b0, if_valid}, 32'd0);
    check("redirect", {31'b0, redirect}, {31'b0, expRedir});
    check("req_reissue", {31'b0, imem_req}, 32'd1);
    check("next_addr", imem_addr, nextAddr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    if_ready   = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    jump       = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_redirect", {31'b0, redirect}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", if_pc, 32'd0);

    rst = 1'b0;
    #1;
    check("rel_req", {31'b0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h0);
    check("rel_valid", {31'b0, if_valid}, 32'd0);
    check("rel_redirect", {31'b0, redirect}, 32'd0);

    // lw at 0 with three wait states
    fetchStep(3, 32'h8C22_0004, 32'h0);
    check("lw_op", {26'b0, if_op}, 32'h23);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h4);

    fetchStep(1, 32'h0000_0020, 32'h4);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h8);

    // beq at 8, offset -2: taken goes back to 4
    fetchStep(0, 32'h1000_FFFE, 32'h8);
    consume(1'b1, 1'b1, 1'b0, 1'b1, 32'h4);

    fetchStep(2, 32'h0000_0000, 32'h4);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h8);

    // beq not taken
    fetchStep(0, 32'h1000_FFFE, 32'h8);
    consume(1'b1, 1'b0, 1'b0, 1'b0, 32'hC);

    fetchStep(0, 32'h0000_0000, 32'hC);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h10);

    // j 0x40 -> 0x100
    fetchStep(0, 32'h0800_0040, 32'h10);
    consume(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);

    // j with branch&zero also high: jump wins
    fetchStep(1, 32'h0800_0040, 32'h100);
    consume(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);

    // decoder back-pressure for 10 cycles
    fetchStep(0, 32'h2001_0005, 32'h100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, if_valid}, 32'd1);
      check("stall_instr", if_instr, 32'h2001_0005);
      check("stall_pc", if_pc, 32'h100);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h104);

`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'(nConsumed));
    check("perf_stall", perf_stall, 32'(nStall));
    check("perf_redirect", {16'b0, perf_redirect}, 32'(nRedirect));
`endif

    // reset while a fetch is waiting for its ack
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_req", {31'b0, imem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_req", {31'b0, imem_req}, 32'd0);
    check("midrst_valid", {31'b0, if_valid}, 32'd0);
    check("midrst_redirect", {31'b0, redirect}, 32'd0);
    check("midrst_instr", if_instr, 32'd0);
    check("midrst_pc", if_pc, 32'd0);
    check("midrst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    check("midrst_perf_fetched", perf_fetched, 32'd0);
    check("midrst_perf_stall", perf_stall, 32'd0);
    check("midrst_perf_redirect", {16'b0, perf_redirect}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("restart_req", {31'b0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    fetchStep(0, 32'h8C22_0004, 32'h0);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h4);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/mips_instr_fetch.md
Name: mips_instr_fetch

Overview:
- Instruction fetch/sequencing stage of the single-issue MIPS core.
- Owns the PC and fetches words from instruction memory over a req/ack handshake.
- Presents each instruction to the opcode decoder (Op = instr[31:26]) with a valid/ready handshake.
- Consumes the decoder's Branch and J controls plus the ALU zero flag, and redirects the PC for taken beq and j.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address; bits [1:0] forced to 0.
- PC_W, 32, PC and address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  PC_W  word-aligned fetch address; stable while imem_req=1.
- imem_ack  in  1  response strobe; imem_rdata valid this cycle. Ignored when imem_req=0.
- imem_rdata  in  32  fetched instruction word.
- if_valid  out  1  instruction available to decoder.
- if_ready  in  1  decoder/datapath consumes instruction.
- if_instr  out  32  held instruction.
- if_op  out  6  if_instr[31:26], feeds decoder Op.
- if_pc  out  PC_W  address of held instruction.
- branch  in  1  decoder Branch; sampled only in the consume cycle.
- zero  in  1  ALU zero flag; sampled only in the consume cycle.
- jump  in  1  decoder J; sampled only in the consume cycle.
- redirect  out  1  one-cycle pulse; high in the cycle after a taken consume.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - pc = RESET_PC.
  - imem_req, if_valid, redirect = 0.
  - if_instr, if_pc = 0.
  - state = FETCH.
- FSM, state FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, imem_req<=0, state<=HOLD.
  - An ack is accepted in any cycle with imem_req=1, including the first request cycle.
- FSM, state HOLD:
  - Outputs held stable while if_ready=0; no request is issued.
  - Consume cycle (if_valid & if_ready): if_valid<=0, state<=FETCH, and pc is updated:
    - jump=1: pc <= {pc4[31:28], if_instr[25:0], 2'b00}, where pc4 = if_pc+4.
    - else branch & zero: pc <= pc4 + (sext(if_instr[15:0]) << 2).
    - else: pc <= pc4.
  - jump takes priority when branch and jump are both high.
  - redirect pulses for one cycle on a taken jump or branch.
- Latency and throughput:
  - Re-request issues the cycle after the consume: one-cycle bubble.
  - Peak throughput is one instruction per 2 cycles with a zero-wait memory.
- Arithmetic: all PC arithmetic wraps modulo 2^PC_W. imem_addr[1:0] is always 0.
- Reset mid-operation: imem_req drops immediately, combinationally from rst.
  - The memory is reset on the same rst, so no stale ack can arrive afterward.
  - Fetch restarts at RESET_PC in the first cycle after rst deasserts.
- branch, zero and jump are don't-care outside the consume cycle.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds three outputs, cleared by rst and saturating at all-ones:
  - perf_fetched (32 b): count of instructions consumed.
  - perf_stall (32 b): cycles in FETCH with imem_req=1 and no ack.
  - perf_redirect (16 b): count of taken redirects.
- When undefined: these ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010, OP_ADDI=6'b001000.
  - Fetch state enum: FETCH, HOLD.
  - INSTR_W=32.
- Sub-module pc_target_calc: combinational pc4, branch target and jump target from (if_pc, if_instr).

Test Plan:
- Reset release → imem_req=1 with imem_addr=0x0 on the first cycle; if_valid=0, redirect=0.
- ack after 3 wait cycles, rdata 0x8C220004 (lw) → if_valid=1, if_op=6'h23, if_pc=0x0. Consume → next imem_addr=0x4.
- beq at 0x8, rdata 0x1000FFFE, consumed with branch=1, zero=1 → next imem_addr=0x4, redirect pulse. With zero=0 → next imem_addr=0xC, no redirect.
- j at 0x10, rdata 0x08000040, consumed with jump=1 → next imem_addr=0x100. Adding branch=1, zero=1 gives the same result: 0x100.
- if_ready held low 10 cycles → if_valid, if_instr and if_pc stable; imem_req=0 throughout.
- rst pulsed while waiting for ack → imem_req low in the same cycle and all outputs 0. After release, fetch restarts at RESET_PC. FETCH_PERF_EN build: perf counters back to 0.
